// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Shared definitions for the RV32I single-cycle core. The decoder,
//   datapath and ALU use them, as does the register file.
//
//   XLEN       : architectural data width
//   REG_AW     : register address width (rs1/rs2/rd fields)
//   reg_addr_t : register address type
//   REG_ZERO   : ABI index of x0 (hardwired zero)
//   REG_RA     : ABI index of x1 (return address)
//   REG_SP     : ABI index of x2 (stack pointer)
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_RA   = 5'd1;
    localparam reg_addr_t REG_SP   = 5'd2;

endpackage : core_pkg

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   Integer register file for the RV32I single-cycle core. It provides two
//   asynchronous read ports and one synchronous write port. x0 is hardwired
//   to zero and has no storage behind it.
//
//   Parameters
//     XLEN     : register/data width
//     NREGS    : number of architectural registers (32 for RV32I, 16 for RV32E)
//     SP_RESET : reset value of x2 (sp); every other register resets to 0
//     BYPASS   : 1 = a write in flight is forwarded to matching read ports in
//                the same cycle. Keep this at 0 in the single-cycle core,
//                where forwarding would close a combinational loop
//                through the ALU.
//
//   Ports
//     clk  in   core clock, rising edge
//     rst  in   synchronous active-high reset; it has priority over a write
//     A1   in   read address, port 1 (rs1)
//     A2   in   read address, port 2 (rs2)
//     A3   in   write address (rd)
//     WE3  in   write enable
//     WD3  in   write data
//     RD1  out  read data, port 1 (ALU operand A)
//     RD2  out  read data, port 2 (operand-B mux / store data)
// -----------------------------------------------------------------------------
module reg_file
    import core_pkg::reg_addr_t, core_pkg::REG_ZERO, core_pkg::REG_SP;
#(
    parameter int              XLEN     = core_pkg::XLEN,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] SP_RESET = '0,
    parameter bit              BYPASS   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  reg_addr_t       A1,
    input  reg_addr_t       A2,
    input  reg_addr_t       A3,
    input  logic            WE3,
    input  logic [XLEN-1:0] WD3,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2
);

    // Storage indexing width. When NREGS is below 32, the upper address
    // bits are ignored on reads.
    localparam int IDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int SP_IDX = int'(REG_SP);

    // Storage covers x1 upward; x0 reads as constant zero.
    logic [XLEN-1:0] mem [1:NREGS-1];

    logic            wr_in_range;
    logic            wr_valid;
    logic            hit1;
    logic            hit2;
    logic [XLEN-1:0] store1;
    logic [XLEN-1:0] store2;

    // A write counts only when its target exists and is not x0. A write to
    // x0 or past NREGS is dropped without any indication.
    assign wr_in_range = (int'(A3) < NREGS);
    assign wr_valid    = WE3 && (A3 != REG_ZERO) && wr_in_range;

    // -------------------------------------------------------------------------
    // Write port. Reset overrides any write presented in the same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                mem[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else if (wr_valid) begin
            for (int i = 1; i < NREGS; i++) begin
                if (A3 == reg_addr_t'(i)) begin
                    mem[i] <= WD3;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read ports: combinational lookup of the current storage. An address
    // that maps to index 0 reads zero.
    // -------------------------------------------------------------------------
    always_comb begin
        store1 = '0;
        store2 = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (A1[IDX_W-1:0] == IDX_W'(i)) store1 = mem[i];
            if (A2[IDX_W-1:0] == IDX_W'(i)) store2 = mem[i];
        end
        if (A1 == REG_ZERO) store1 = '0;
        if (A2 == REG_ZERO) store2 = '0;
    end

    // Write-first forwarding. Each port decides independently, so both
    // ports forward when they both match rd.
    assign hit1 = BYPASS && wr_valid && (A3 == A1);
    assign hit2 = BYPASS && wr_valid && (A3 == A2);

    assign RD1 = hit1 ? WD3 : store1;
    assign RD2 = hit2 ? WD3 : store2;

endmodule : reg_file
